// File: rtl/link_pkg.sv
// Shared definitions for the inter-FPGA credit link (transmit and receive sides).
package link_pkg;

    // Widest flit (payload + sop + parity) that even_parity accepts.
    localparam int PARITY_MAX_W = 64;

    // Bit position of the start-of-message flag inside a flit.
    function automatic int link_sop_bit(input int physWidth);
        return physWidth;
    endfunction

    // Bit position of the parity bit inside a flit.
    function automatic int link_par_bit(input int physWidth);
        return physWidth + 1;
    endfunction

    // Total flit width on the wire: payload, sop and parity.
    function automatic int flit_width(input int physWidth);
        return physWidth + 2;
    endfunction

    // Parity bit that makes the covered bits plus itself an even count of ones.
    // Narrower operands are zero-extended by the caller, which does not change the result.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
// Shared by the transmit side (send/return) and the receive side (return accounting).
module credit_counter #(
    parameter int MAX = 16,
    localparam int W  = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         overflow_o
);

    logic [W-1:0] count_q, count_d;
    logic         overflow_q, overflow_d;

    // Next count: inc and dec together cancel; inc at MAX saturates and flags overflow.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (dec_i && !inc_i) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end
        end else if (inc_i && !dec_i) begin
            if (count_q == W'(MAX)) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register starts full; overflow flag is cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= W'(MAX);
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/link_credit_tx.sv
// Transmit link stage: pops flits from the narrow out FIFO, frames them with
// sop/parity and drives the physical link under credit-based flow control.
module link_credit_tx
    import link_pkg::*;
#(
    parameter int HUB_FIFO_WIDTH          = 32,
    parameter int HUB_FIFO_PHYSICAL_WIDTH = 8,
    parameter int CREDITS                 = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               tx_enable_i,
    input  logic [HUB_FIFO_PHYSICAL_WIDTH-1:0] fifo_data_i,
    input  logic                               fifo_valid_i,
    output logic                               fifo_ready_o,
    output logic [HUB_FIFO_PHYSICAL_WIDTH+1:0] link_data_o,
    output logic                               link_valid_o,
    input  logic                               credit_return_i,
    output logic                               busy_o,
    output logic                               credit_overflow_o
);

    localparam int WORDS_PER_MSG = HUB_FIFO_WIDTH / HUB_FIFO_PHYSICAL_WIDTH;
    localparam int WORD_CNT_W    = (WORDS_PER_MSG > 1) ? $clog2(WORDS_PER_MSG) : 1;
    localparam int CREDIT_W      = $clog2(CREDITS + 1);
    localparam int FLIT_W        = flit_width(HUB_FIFO_PHYSICAL_WIDTH);
    localparam int LINK_SOP_BIT  = link_sop_bit(HUB_FIFO_PHYSICAL_WIDTH);
    localparam int LINK_PAR_BIT  = link_par_bit(HUB_FIFO_PHYSICAL_WIDTH);

    if ((HUB_FIFO_WIDTH % HUB_FIFO_PHYSICAL_WIDTH) != 0 || WORDS_PER_MSG < 1) begin : g_bad_msg_width
        $error("link_credit_tx: HUB_FIFO_WIDTH must be a positive multiple of HUB_FIFO_PHYSICAL_WIDTH");
    end
    if (FLIT_W > PARITY_MAX_W) begin : g_bad_flit_width
        $error("link_credit_tx: flit wider than even_parity supports");
    end
    if (CREDITS < 1) begin : g_bad_credits
        $error("link_credit_tx: CREDITS must be at least 1");
    end

    logic [CREDIT_W-1:0]   credits;
    logic                  send;
    logic                  sop;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [FLIT_W-1:0]     link_data_q, link_data_d;
    logic                  link_valid_q, link_valid_d;

    // The credit check uses the registered count, so a return only helps from the next cycle.
    assign send         = tx_enable_i && fifo_valid_i && (credits != '0);
    assign fifo_ready_o = send;
    assign sop          = (word_cnt_q == '0);

    credit_counter #(
        .MAX (CREDITS)
    ) u_credits (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (credit_return_i),
        .dec_i      (send),
        .count_o    (credits),
        .overflow_o (credit_overflow_o)
    );

    // Frame the popped word and advance the position within the message.
    always_comb begin
        word_cnt_d   = word_cnt_q;
        link_data_d  = link_data_q;
        link_valid_d = 1'b0;
        if (send) begin
            word_cnt_d   = (word_cnt_q == WORD_CNT_W'(WORDS_PER_MSG - 1)) ? '0 : word_cnt_q + 1'b1;
            link_valid_d = 1'b1;
            link_data_d[HUB_FIFO_PHYSICAL_WIDTH-1:0] = fifo_data_i;
            link_data_d[LINK_SOP_BIT]                = sop;
            link_data_d[LINK_PAR_BIT]                = even_parity(PARITY_MAX_W'({sop, fifo_data_i}));
        end
    end

    // Link output and word position registers; reset abandons any partial message.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt_q   <= '0;
            link_data_q  <= '0;
            link_valid_q <= 1'b0;
        end else begin
            word_cnt_q   <= word_cnt_d;
            link_data_q  <= link_data_d;
            link_valid_q <= link_valid_d;
        end
    end

    assign link_data_o  = link_data_q;
    assign link_valid_o = link_valid_q;
    assign busy_o       = link_valid_q || (credits != CREDIT_W'(CREDITS)) || (word_cnt_q != '0);

endmodule

// File: tb/tb_link_credit_tx.sv
// Directed and random-backpressure bench for link_credit_tx (32-bit messages, 8-bit flits, 4 credits).
module tb_link_credit_tx;

    localparam int HUB_FIFO_WIDTH = 32;
    localparam int PHYS           = 8;
    localparam int CREDITS        = 4;
    localparam int RAND_BYTES     = 400;
    localparam int RAND_LIMIT     = 20000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        txEnable = 1'b0;
    logic [7:0]  fifoData = 8'h00;
    logic        fifoValid = 1'b0;
    logic        fifoReady;
    logic [9:0]  linkData;
    logic        linkValid;
    logic        creditReturn = 1'b0;
    logic        busy;
    logic        creditOverflow;

    int          assertCount = 0;
    int          failCount = 0;
    logic [7:0]  fifoQ[$];
    logic        readyNow;

    link_credit_tx #(
        .HUB_FIFO_WIDTH          (HUB_FIFO_WIDTH),
        .HUB_FIFO_PHYSICAL_WIDTH (PHYS),
        .CREDITS                 (CREDITS)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .tx_enable_i       (txEnable),
        .fifo_data_i       (fifoData),
        .fifo_valid_i      (fifoValid),
        .fifo_ready_o      (fifoReady),
        .link_data_o       (linkData),
        .link_valid_o      (linkValid),
        .credit_return_i   (creditReturn),
        .busy_o            (busy),
        .credit_overflow_o (creditOverflow)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case something blocks forever.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveFifo();
        fifoValid = (fifoQ.size() != 0);
        fifoData  = (fifoQ.size() != 0) ? fifoQ[0] : 8'h00;
    endtask

    // One clock: drive inputs, capture combinational ready, clock, pop the FIFO model.
    task automatic applyStimulus(input logic en, input logic ret);
        txEnable     = en;
        creditReturn = ret;
        driveFifo();
        #1;
        readyNow = fifoReady;
        tick();
        if (readyNow && fifoQ.size() != 0) void'(fifoQ.pop_front());
    endtask

    task automatic resetDut();
        reset        = 1'b1;
        txEnable     = 1'b0;
        creditReturn = 1'b0;
        fifoQ.delete();
        driveFifo();
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [9:0] t1Exp[4];
        logic [9:0] t3Exp[4];
        logic       t4Ready[5];
        logic [7:0] sent[$];
        logic [2:0] retPipe;
        logic       en, ret, expReady, expSop, expPar;
        logic [9:0] expFlit;
        int         modelCredits, rxIdx, cyc;

        // Reset state
        resetDut();
        checkOutput("reset_link_valid", 32'(linkValid), 32'd0);
        checkOutput("reset_link_data", 32'(linkData), 32'h000);
        checkOutput("reset_overflow", 32'(creditOverflow), 32'd0);
        checkOutput("reset_fifo_ready", 32'(fifoReady), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);

        // Single message, back-to-back, one cycle latency
        $display("[TB] single message");
        fifoQ = '{8'h11, 8'h22, 8'h33, 8'h44};
        t1Exp = '{10'h311, 10'h022, 10'h033, 10'h044};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("t1_ready", 32'(readyNow), 32'd1);
            checkOutput("t1_valid", 32'(linkValid), 32'd1);
            checkOutput("t1_data", 32'(linkData), 32'(t1Exp[i]));
            checkOutput("t1_busy", 32'(busy), 32'd1);
        end

        // Credit stall, then a single return releases one flit a cycle later
        $display("[TB] credit stall");
        fifoQ.push_back(8'h55);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("t2_stall_ready", 32'(readyNow), 32'd0);
            checkOutput("t2_stall_valid", 32'(linkValid), 32'd0);
            checkOutput("t2_stall_busy", 32'(busy), 32'd1);
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("t2_ready_same_cycle_as_return", 32'(readyNow), 32'd0);
        checkOutput("t2_valid_after_return", 32'(linkValid), 32'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t2_ready_after_return", 32'(readyNow), 32'd1);
        checkOutput("t2_valid", 32'(linkValid), 32'd1);
        checkOutput("t2_data", 32'(linkData), 32'h355);

        // Bring credits to 2, then simultaneous send+return keeps them at 2
        $display("[TB] simultaneous send and return");
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        fifoQ = '{8'h01, 8'h02, 8'h03, 8'h04};
        t3Exp = '{10'h201, 10'h202, 10'h003, 10'h104};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("t3_pair_ready", 32'(readyNow), 32'd1);
            checkOutput("t3_pair_data", 32'(linkData), 32'(t3Exp[i]));
        end
        fifoQ = '{8'h05, 8'h06, 8'h07};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("t3_drain_ready", 32'(readyNow), (i < 2) ? 32'd1 : 32'd0);
            checkOutput("t3_drain_valid", 32'(linkValid), (i < 2) ? 32'd1 : 32'd0);
            if (i == 0) checkOutput("t3_drain_data0", 32'(linkData), 32'h005);
            if (i == 1) checkOutput("t3_drain_data1", 32'(linkData), 32'h006);
        end
        repeat (4) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t3_last_data", 32'(linkData), 32'h207);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t3_idle_busy", 32'(busy), 32'd0);
        checkOutput("t3_idle_overflow", 32'(creditOverflow), 32'd0);

        // Overflow at idle: saturate and stick until reset
        $display("[TB] credit overflow");
        applyStimulus(1'b0, 1'b1);
        checkOutput("t4_overflow_set", 32'(creditOverflow), 32'd1);
        checkOutput("t4_busy_at_full", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t4_overflow_sticky", 32'(creditOverflow), 32'd1);
        fifoQ   = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        t4Ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("t4_saturated_ready", 32'(readyNow), 32'(t4Ready[i]));
        end
        resetDut();
        checkOutput("t4_overflow_cleared", 32'(creditOverflow), 32'd0);
        checkOutput("t4_reset_busy", 32'(busy), 32'd0);
        checkOutput("t4_reset_data", 32'(linkData), 32'h000);

        // Pause keeps the word position; reset mid-message restarts framing
        $display("[TB] pause and reset mid-message");
        fifoQ = '{8'h10, 8'h20, 8'h30};
        applyStimulus(1'b1, 1'b0);
        checkOutput("t5_data0", 32'(linkData), 32'h110);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t5_data1", 32'(linkData), 32'h220);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("t5_pause_ready", 32'(readyNow), 32'd0);
            checkOutput("t5_pause_valid", 32'(linkValid), 32'd0);
            checkOutput("t5_pause_busy", 32'(busy), 32'd1);
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput("t5_resume_data", 32'(linkData), 32'h030);
        resetDut();
        checkOutput("t5_reset_busy", 32'(busy), 32'd0);
        fifoQ = '{8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus(1'b1, 1'b0);
        checkOutput("t5_post_reset_data", 32'(linkData), 32'h140);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("t5_post_reset_credits", 32'(readyNow), (i < 3) ? 32'd1 : 32'd0);
        end
        resetDut();

        // Random enable pattern with a 3-cycle credit return loop and a scoreboard
        $display("[TB] random back-pressure");
        for (int i = 0; i < RAND_BYTES; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            fifoQ.push_back(b);
            sent.push_back(b);
        end
        modelCredits = CREDITS;
        rxIdx        = 0;
        cyc          = 0;
        retPipe      = 3'b000;
        while ((rxIdx < RAND_BYTES || modelCredits != CREDITS) && cyc < RAND_LIMIT) begin
            ret      = retPipe[2];
            en       = ($urandom_range(0, 3) != 0);
            expReady = en && (fifoQ.size() != 0) && (modelCredits != 0);
            applyStimulus(en, ret);
            checkOutput("rand_ready", 32'(readyNow), 32'(expReady));
            checkOutput("rand_valid", 32'(linkValid), 32'(expReady));
            modelCredits = modelCredits - int'(expReady) + int'(ret);
            if (linkValid) begin
                if (rxIdx < RAND_BYTES) begin
                    expSop  = ((rxIdx % 4) == 0);
                    expPar  = ^{expSop, sent[rxIdx]};
                    expFlit = {expPar, expSop, sent[rxIdx]};
                    checkOutput("rand_flit", 32'(linkData), 32'(expFlit));
                    checkOutput("rand_even_parity", 32'(^linkData), 32'd0);
                end else begin
                    checkOutput("rand_extra_flit", 32'(rxIdx), 32'(RAND_BYTES - 1));
                end
                rxIdx++;
            end
            retPipe = {retPipe[1:0], linkValid};
            cyc++;
        end
        checkOutput("rand_finished_in_time", 32'(cyc < RAND_LIMIT), 32'd1);
        checkOutput("rand_flit_count", 32'(rxIdx), 32'(RAND_BYTES));
        applyStimulus(1'b0, 1'b0);
        checkOutput("rand_end_busy", 32'(busy), 32'd0);
        checkOutput("rand_end_overflow", 32'(creditOverflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
